// File: rtl/prbs7_frame_gen.sv
// Purpose : PRBS7 (x^7+x^6+1) 32-bit word source with user-data merge, error injection, bit-slip rotate and bit-reverse map.
// Latency : 2 enabled cycles from raw PRBS generation to dout/dvalid; restart blanks dvalid for the 2 following cycles.
// Backpres: none; enable=0 freezes the generator, both pipeline stages and the injection FSM, and holds dvalid low.
module prbs7_frame_gen #(
    parameter logic [6:0] SEED    = 7'h7F,
    parameter int         GAP_MIN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        restart,
    input  logic [15:0] mask,
    input  logic [31:0] user_data,
    input  logic [4:0]  rot,
    input  logic        map_en,
    input  logic        inj_req,
    input  logic [4:0]  inj_bit,
    input  logic [7:0]  inj_count,
    output logic        inj_busy,
    output logic [31:0] dout,
    output logic        dvalid,
    output logic [31:0] word_count,
    output logic [15:0] err_count
);

    // An all-zero LFSR state would lock up, so it is replaced by all-ones.
    localparam logic [6:0] SEED_EFF = (SEED == 7'h00) ? 7'h7F : SEED;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_FLIP = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam logic [7:0] GAP_LAST = 8'(GAP_MIN - 1);

    // Runs the LFSR 32 steps; bit 0 of the word is produced first.
    // Returns {next_state, word}.
    function automatic logic [38:0] prbs_step32(input logic [6:0] s);
        logic [6:0]  st;
        logic [31:0] wd;
        st = s;
        wd = '0;
        for (int i = 0; i < 32; i++) begin
            wd[i] = st[0] ^ st[1];
            st    = {wd[i], st[6:1]};
        end
        return {st, wd};
    endfunction

    function automatic logic [31:0] bit_reverse(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int k = 0; k < 32; k++) begin
            y[k] = x[31-k];
        end
        return y;
    endfunction

    logic [6:0]  r_prbs;
    logic [31:0] r_raw;
    logic        r_s1_vld;
    logic [31:0] r_dout;
    logic        r_dvalid;
    logic [31:0] r_word_cnt;
    logic [15:0] r_err_cnt;
    logic [1:0]  r_state;
    logic [4:0]  r_inj_bit;
    logic [7:0]  r_inj_left;
    logic [7:0]  r_gap_cnt;

    logic [38:0] w_step;
    logic [31:0] w_mask32;
    logic [31:0] w_merged;
    logic        w_flip;
    logic [31:0] w_injected;
    logic [63:0] w_dbl;
    logic [31:0] w_rotated;
    logic [31:0] w_mapped;
    logic        w_adv;

    assign w_adv      = enable & ~restart;
    assign w_step     = prbs_step32(r_prbs);
    assign w_mask32   = {mask, mask};
    assign w_merged   = (r_raw & ~w_mask32) | (user_data & w_mask32);
    assign w_flip     = (r_state == ST_FLIP);
    assign w_injected = w_flip ? (w_merged ^ (32'd1 << r_inj_bit)) : w_merged;
    // Rotate-left through a doubled word: rot=0 leaves the upper half unchanged.
    assign w_dbl      = {w_injected, w_injected} << rot;
    assign w_rotated  = w_dbl[63:32];
    assign w_mapped   = map_en ? bit_reverse(w_rotated) : w_rotated;

    // Generator and two-stage output pipeline; restart reseeds and empties stage 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prbs   <= SEED_EFF;
            r_raw    <= '0;
            r_s1_vld <= 1'b0;
            r_dout   <= '0;
            r_dvalid <= 1'b0;
        end else if (restart) begin
            r_prbs   <= SEED_EFF;
            r_raw    <= '0;
            r_s1_vld <= 1'b0;
            r_dvalid <= 1'b0;
        end else if (enable) begin
            r_prbs   <= w_step[38:32];
            r_raw    <= w_step[31:0];
            r_s1_vld <= 1'b1;
            r_dout   <= w_mapped;
            r_dvalid <= r_s1_vld;
        end else begin
            r_dvalid <= 1'b0;
        end
    end

    // Statistics: word counter wraps, error counter saturates; restart leaves both alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (w_adv) begin
            if (r_s1_vld) begin
                r_word_cnt <= r_word_cnt + 32'd1;
            end
            if (w_flip && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    // Injection sequencer: ARM, then FLIP / GAP alternation until the count is spent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_inj_bit  <= '0;
            r_inj_left <= '0;
            r_gap_cnt  <= '0;
        end else if (restart) begin
            r_state <= ST_IDLE;
        end else if (enable) begin
            case (r_state)
                ST_IDLE: begin
                    if (inj_req && (inj_count != 8'd0)) begin
                        r_inj_bit  <= inj_bit;
                        r_inj_left <= inj_count;
                        r_state    <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    r_state <= ST_FLIP;
                end
                ST_FLIP: begin
                    r_inj_left <= r_inj_left - 8'd1;
                    r_gap_cnt  <= '0;
                    r_state    <= (r_inj_left == 8'd1) ? ST_IDLE : ST_GAP;
                end
                default: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= ST_FLIP;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    assign inj_busy   = (r_state != ST_IDLE);
    assign dout       = r_dout;
    assign dvalid     = r_dvalid;
    assign word_count = r_word_cnt;
    assign err_count  = r_err_cnt;

endmodule
